// File: rtl/imem_prefetch_pkg.sv
// Shared types for the instruction prefetch buffer: one FIFO entry per fetched word.
// Types and constants only, so there is no latency or backpressure behaviour here.
package imem_prefetch_pkg;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } fetch_entry_t;

    localparam logic [31:0] WORD_BYTES = 32'd4;

endpackage

// File: rtl/prefetch_fifo.sv
// Sync FIFO of fetched words with flush and a two-entry head window. A push is visible
// one cycle after it is written. There is no backpressure; the caller's credit scheme keeps it from overflowing.
module prefetch_fifo
    import imem_prefetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  fetch_entry_t     push_entry,
    input  logic             pop,
    output fetch_entry_t     head0,
    output fetch_entry_t     head1,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t     entries [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (push && !flush) entries[wr_ptr] <= push_entry;
    end

    assign head0 = entries[rd_ptr];
    assign head1 = entries[rd_ptr + PTR_W'(1)];

endmodule

// File: rtl/imem_prefetch_buffer.sv
// Sequential instruction prefetcher between the core imem port and a req/gnt/rvalid memory. A hit costs zero cycles, and a redirect takes 3 cycles to its first word with a 1-cycle memory.
// Fetch requests stop when FIFO entries plus outstanding fetches reach DEPTH. The core is never stalled except by waiting for data.
module imem_prefetch_buffer
    import imem_prefetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        core_req,
    input  logic [31:0] core_addr,
    output logic [31:0] core_rdata,
    output logic        core_ready,
    output logic        core_err,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        mem_err
);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W:0]   in_use;
    logic [31:0]      head_addr;
    logic [31:0]      fetch_addr;
    fetch_entry_t     entry0;
    fetch_entry_t     entry1;
    fetch_entry_t     push_entry;
    logic             hit0;
    logic             hit1;
    logic             waiting;
    logic             redirect;
    logic             issue;
    logic             resp;
    logic             drop;
    logic             push;

    assign hit0     = core_req && (count >= CNT_W'(1)) && (core_addr == head_addr);
    assign hit1     = core_req && (count >= CNT_W'(2)) && (core_addr == head_addr + WORD_BYTES);
    // An empty FIFO at the requested PC means its first word is already on the way.
    assign waiting  = (count == '0) && (core_addr == head_addr);
    assign redirect = core_req && !hit0 && !hit1 && !waiting;

    assign in_use   = {1'b0, count} + {1'b0, outstanding};
    assign mem_req  = core_req && !redirect && (in_use < (CNT_W+1)'(DEPTH));
    assign mem_addr = fetch_addr;
    assign issue    = mem_req && mem_gnt;

    // Responses that arrive when nothing is outstanding (e.g. just after reset) are ignored.
    assign resp = mem_rvalid && (outstanding != '0);
    assign drop = resp && (drop_cnt != '0);
    assign push = resp && !drop && !redirect;

    assign push_entry = '{data: mem_rdata, err: mem_err};

    always_comb begin
        core_ready = hit0 || hit1;
        core_rdata = '0;
        core_err   = 1'b0;
        if (hit0) begin
            core_rdata = entry0.data;
            core_err   = entry0.err;
        end else if (hit1) begin
            core_rdata = entry1.data;
            core_err   = entry1.err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
            drop_cnt    <= '0;
            head_addr   <= '0;
            fetch_addr  <= '0;
        end else begin
            outstanding <= outstanding + CNT_W'(issue) - CNT_W'(resp);
            // On redirect, every fetch still in flight belongs to the old stream.
            if (redirect)  drop_cnt <= outstanding - CNT_W'(resp);
            else if (drop) drop_cnt <= drop_cnt - CNT_W'(1);
            if (redirect)  head_addr <= core_addr;
            else if (hit1) head_addr <= head_addr + WORD_BYTES;
            if (redirect)   fetch_addr <= core_addr;
            else if (issue) fetch_addr <= fetch_addr + WORD_BYTES;
        end
    end

    prefetch_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect),
        .push       (push),
        .push_entry (push_entry),
        .pop        (hit1),
        .head0      (entry0),
        .head1      (entry1),
        .count      (count)
    );

endmodule

// File: tb/tb_imem_prefetch_buffer.sv
// Directed and random stimulus for imem_prefetch_buffer against a queue-based model of the
// prefetch stream and a pipelined in-order memory with configurable latency.
module tb_imem_prefetch_buffer;
    import imem_prefetch_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_req;
    logic [31:0] core_addr;
    logic [31:0] core_rdata;
    logic        core_ready;
    logic        core_err;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_err;

    always #5 clk = ~clk;

    imem_prefetch_buffer #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .core_req   (core_req),
        .core_addr  (core_addr),
        .core_rdata (core_rdata),
        .core_ready (core_ready),
        .core_err   (core_err),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .mem_err    (mem_err)
    );

    typedef struct { logic [31:0] addr; int due; }                    mreq_t;
    typedef struct { logic [31:0] addr; bit stale; }                  fly_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; logic err; } buf_t;

    mreq_t       mq[$];
    fly_t        fly[$];
    buf_t        bq[$];
    logic [31:0] m_head, m_fetch, err_addr, last_issue;
    int          cyc, last_due, lat, vectors, miscompares;
    bit          rand_gnt, rand_lat, wrap_seen;
    logic        obs_ready, obs_err, obs_mreq;
    logic [31:0] obs_data;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1000 + (a >> 2);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive memory, check outputs against the model, advance the model.
    task automatic step();
        bit          rv, e_hit0, e_hit1, e_redir, e_req;
        logic [31:0] e_data;
        logic        e_err;
        int          due;
        fly_t        f;
        rv = (mq.size() > 0) && (mq[0].due <= cyc);
        mem_rvalid = rv;
        if (rv) begin
            mem_rdata = mem_word(mq[0].addr);
            mem_err   = (mq[0].addr == err_addr);
        end else begin
            mem_rdata = $urandom;
            mem_err   = 1'($urandom_range(0, 1));
        end
        mem_gnt = rand_gnt ? ($urandom_range(0, 9) < 7) : 1'b1;

        e_hit0 = 0; e_hit1 = 0; e_data = '0; e_err = 1'b0;
        if (core_req && bq.size() >= 1 && bq[0].addr == core_addr) begin
            e_hit0 = 1; e_data = bq[0].data; e_err = bq[0].err;
        end else if (core_req && bq.size() >= 2 && bq[1].addr == core_addr) begin
            e_hit1 = 1; e_data = bq[1].data; e_err = bq[1].err;
        end
        e_redir = core_req && !e_hit0 && !e_hit1 && !(bq.size() == 0 && core_addr == m_head);
        e_req   = core_req && !e_redir && (bq.size() + fly.size() < DEPTH);

        #1;
        obs_ready = core_ready; obs_data = core_rdata; obs_err = core_err; obs_mreq = mem_req;
        chk("core_ready", core_ready, e_hit0 || e_hit1);
        chk("core_rdata", core_rdata, e_data);
        chk("mem_req", mem_req, e_req);
        if (e_req) chk("mem_addr", mem_addr, m_fetch);
        if (core_ready) begin
            chk("core_err", core_err, e_err);
            chk("served_word", core_rdata, mem_word(core_addr));
        end
        chk("credit_invariant", (int'(dut.count) + int'(dut.outstanding)) <= DEPTH, 1);

        if (mem_req && mem_gnt) begin
            due = cyc + (rand_lat ? int'($urandom_range(1, 3)) : lat);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mq.push_back('{mem_addr, due});
            if (last_issue == 32'hFFFF_FFFC && mem_addr == 32'h0) wrap_seen = 1;
            last_issue = mem_addr;
        end
        if (rv) mq.delete(0);

        if (rv && fly.size() > 0) begin
            f = fly.pop_front();
            if (!f.stale && !e_redir) bq.push_back('{f.addr, mem_rdata, mem_err});
        end
        if (e_hit1) begin
            bq.delete(0);
            m_head += 32'd4;
        end
        if (e_redir) begin
            bq.delete();
            foreach (fly[i]) fly[i].stale = 1;
            m_head  = core_addr;
            m_fetch = core_addr;
        end
        if (e_req && mem_gnt) begin
            fly.push_back('{m_fetch, 1'b0});
            m_fetch += 32'd4;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic wait_ready(input string tag, input int limit);
        for (int i = 0; i < limit; i++) begin
            step();
            if (obs_ready) break;
        end
        chk(tag, obs_ready, 1'b1);
    endtask

    task automatic run_seq(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            if (obs_ready) core_addr += 32'd4;
        end
    endtask

    initial begin
        int first, hits, r;
        bit zero_hit;
        vectors = 0; miscompares = 0; cyc = 0; last_due = 0; lat = 1;
        rand_gnt = 0; rand_lat = 0; wrap_seen = 0; last_issue = '0;
        err_addr = 32'hFFFF_FFFF;
        m_head = '0; m_fetch = '0;
        rst_n = 1'b0; core_req = 1'b0; core_addr = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_err = 1'b0;

        #2;
        chk("reset_core_ready", core_ready, 1'b0);
        chk("reset_core_err", core_err, 1'b0);
        chk("reset_core_rdata", core_rdata, 32'h0);
        chk("reset_mem_req", mem_req, 1'b0);
        chk("reset_mem_addr", mem_addr, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Cold start at PC 0, then straight-line code.
        core_req = 1'b1; core_addr = 32'h0; first = -1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (obs_ready) begin
                first = i;
                break;
            end
        end
        chk("first_ready_cycle", first, 2);
        chk("first_word", obs_data, 32'h1000);
        core_addr = 32'h4; hits = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (obs_ready) begin
                hits++;
                core_addr += 32'd4;
            end
        end
        chk("stream_hits", hits, 12);

        // Hold one PC while the FIFO fills.
        core_addr = 32'h8;
        repeat (8) step();
        chk("hold_ready", obs_ready, 1'b1);
        chk("hold_data", obs_data, mem_word(32'h8));
        chk("hold_full_no_req", obs_mreq, 1'b0);

        // Jump away with three fetches outstanding on a 3-cycle memory.
        lat = 3; core_addr = 32'h200;
        repeat (4) step();
        core_addr = 32'h100;
        wait_ready("jump_ready", 20);
        chk("jump_word", obs_data, mem_word(32'h100));
        core_addr += 32'd4;
        run_seq(8);

        // Error word and its clean successor.
        lat = 1; err_addr = 32'h10; core_addr = 32'h10;
        wait_ready("err_ready", 10);
        chk("err_flag", obs_err, 1'b1);
        core_addr = 32'h14;
        step();
        chk("after_err_ready", obs_ready, 1'b1);
        chk("after_err_flag", obs_err, 1'b0);

        // Core sleeps with two fetches in flight, then resumes at the same PC.
        lat = 3; core_addr = 32'h300;
        repeat (3) step();
        core_req = 1'b0;
        repeat (6) step();
        chk("sleep_no_req", obs_mreq, 1'b0);
        core_req = 1'b1;
        step();
        chk("resume_ready", obs_ready, 1'b1);
        chk("resume_word", obs_data, mem_word(32'h300));
        core_addr = 32'h304;
        step();
        chk("resume_next_ready", obs_ready, 1'b1);

        // Sequential fetch across the top of the address space.
        lat = 1; core_addr = 32'hFFFF_FFF0; wrap_seen = 0; zero_hit = 0;
        for (int i = 0; i < 14; i++) begin
            step();
            if (obs_ready) begin
                if (core_addr == 32'h0) zero_hit = 1;
                core_addr += 32'd4;
            end
        end
        chk("wrap_issue", wrap_seen, 1'b1);
        chk("wrap_hit_zero", zero_hit, 1'b1);

        // Random gnt, latency and core behaviour.
        rand_gnt = 1; rand_lat = 1; err_addr = 32'h20; core_addr = 32'h0;
        for (int i = 0; i < 600; i++) begin
            step();
            r = int'($urandom_range(0, 99));
            if (!core_req) begin
                if (r < 25) core_req = 1'b1;
            end else if (obs_ready) begin
                if (r < 70)      core_addr += 32'd4;
                else if (r >= 95) core_req = 1'b0;
                else if (r >= 85) core_addr = 32'($urandom_range(0, 63)) << 2;
            end else if (r < 5) begin
                core_addr = 32'($urandom_range(0, 63)) << 2;
            end
        end

        // Reset in mid-stream; late responses must be ignored.
        core_req = 1'b0; rst_n = 1'b0;
        #1;
        chk("midreset_core_ready", core_ready, 1'b0);
        chk("midreset_mem_req", mem_req, 1'b0);
        chk("midreset_mem_addr", mem_addr, 32'h0);
        bq.delete(); fly.delete(); m_head = '0; m_fetch = '0;
        repeat (2) step();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (mq.size() == 0) break;
            step();
        end
        core_req = 1'b1; core_addr = 32'h40;
        wait_ready("post_reset_ready", 12);
        chk("post_reset_word", obs_data, mem_word(32'h40));
        core_addr += 32'd4;
        run_seq(6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
